// File: rtl/execute_mdu.sv
// execute_mdu: iterative RV64M multiply/divide unit; define MDU_FAST_MUL_EN for a single-cycle multiply
module execute_mdu #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int H = XLEN / 2;
`ifdef MDU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nx;
  logic accept, sa_op, sb_op, sa, sb, is_div, dz, ovf, special, last;
  logic [XLEN-1:0] xa, xb, ma_in, mb_in, min_v, sp_res;
  logic [XLEN-1:0] mplr, rem, quo, dvs, rem_nx, quo_nx, mul_res, div_res;
  logic [2*XLEN-1:0] acc, mcand, acc_nx, prod_s;
  logic [XLEN:0] rs, rd;
  logic [1:0] op_r;
  logic word_r, neg_q, neg_r;
  logic [CNT_W-1:0] cnt;

  function automatic logic [XLEN-1:0] wsext(input logic w, input logic [XLEN-1:0] x);
    return w ? {{(XLEN-32){x[31]}}, x[31:0]} : x;
  endfunction

  assign sa_op   = !(op == 3'd3 || op == 3'd5 || op == 3'd7);
  assign sb_op   = sa_op && op != 3'd2;
  assign xa      = word ? {{H{sa_op & a[H-1]}}, a[H-1:0]} : a;
  assign xb      = word ? {{H{sb_op & b[H-1]}}, b[H-1:0]} : b;
  assign sa      = sa_op & xa[XLEN-1];
  assign sb      = sb_op & xb[XLEN-1];
  assign ma_in   = sa ? -xa : xa;
  assign mb_in   = sb ? -xb : xb;
  assign is_div  = op[2];
  assign dz      = xb == '0;
  assign min_v   = word ? {{(H+1){1'b1}}, {(H-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
  assign ovf     = sa_op && sb_op && xa == min_v && xb == '1;
  assign special = is_div && (dz || ovf);
  assign sp_res  = wsext(word, op[1] ? (dz ? xa : '0) : (dz ? '1 : xa));
  assign accept  = (state == IDLE || state == DONE) && start && !flush;
  assign busy    = state == MUL || state == DIV;
  assign done    = state == DONE;
  assign last    = cnt == (word_r ? CNT_W'(H - 1) : CNT_W'(XLEN - 1));
  assign acc_nx  = acc + (mplr[0] ? mcand : '0);
  assign rs      = {rem, quo[XLEN-1]};
  assign rd      = rs - {1'b0, dvs};
  assign rem_nx  = rd[XLEN] ? rs[XLEN-1:0] : rd[XLEN-1:0];
  assign quo_nx  = {quo[XLEN-2:0], !rd[XLEN]};
  assign prod_s  = neg_q ? -acc_nx : acc_nx;
  assign mul_res = wsext(word_r, op_r == 2'd0 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);
  assign div_res = wsext(word_r, op_r[1] ? (neg_r ? -rem_nx : rem_nx) : (neg_q ? -quo_nx : quo_nx));
`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fprod;
  logic [XLEN-1:0] fast_res;
  assign fprod    = {{XLEN{sa}}, xa} * {{XLEN{sb}}, xb};
  assign fast_res = wsext(word, op[1:0] == 2'd0 ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN]);
`endif

  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;

  // next state: flush dominates, special divides and fast multiplies skip iteration
  always_comb begin
    state_nx = state;
    if (flush) state_nx = IDLE;
    else if (accept) state_nx = (special || (!is_div && FAST)) ? DONE : (is_div ? DIV : MUL);
    else if (state == DONE) state_nx = IDLE;
    else if (busy && last) state_nx = DONE;
  end

  // datapath: latch magnitudes on accept, one shift-add or restoring step per busy cycle
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt    <= '0;
      result <= '0;
      op_r   <= '0;
      word_r <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplr   <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
    end else if (accept) begin
      op_r   <= op[1:0];
      word_r <= word;
      neg_q  <= sa ^ sb;
      neg_r  <= sa;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{XLEN{1'b0}}, ma_in};
      mplr   <= mb_in;
      rem    <= '0;
      quo    <= word ? {ma_in[H-1:0], {H{1'b0}}} : ma_in;
      dvs    <= mb_in;
      if (special) result <= sp_res;
`ifdef MDU_FAST_MUL_EN
      else if (!is_div) result <= fast_res;
`endif
    end else if (busy && !flush) begin
      cnt   <= cnt + CNT_W'(1);
      acc   <= acc_nx;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      rem   <= rem_nx;
      quo   <= quo_nx;
      if (last) result <= state == MUL ? mul_res : div_res;
    end
endmodule

// File: tb/tb_execute_mdu.sv
// tb_execute_mdu: directed and random checks of execute_mdu against an arithmetic reference
module tb_execute_mdu;
  logic clk = 1'b0;
  logic reset, start, word, flush, busy, done;
  logic [2:0] op;
  logic [63:0] a, b, result, held;
  int nchk = 0;
  int nfail = 0;
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
`ifdef MDU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  execute_mdu dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .word(word),
    .a(a), .b(b), .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic w, input logic [63:0] x, input logic [63:0] y);
    logic signed [127:0] px, py;
    logic [127:0] p;
    logic [31:0] r;
    int x32, y32;
    longint sx, sy;
    logic ov;
    x32 = x[31:0];
    y32 = y[31:0];
    sx = x;
    sy = y;
    ov = w ? (x[31:0] == 32'h8000_0000 && y[31:0] == '1) : (x == MIN && y == '1);
    r = '0;
    if (w) begin
      if (o == 3'd0) r = x[31:0] * y[31:0];
      else if (y[31:0] == 0) r = o[1] ? x[31:0] : '1;
      else if (ov && !o[0]) r = o[1] ? '0 : x[31:0];
      else if (o == 3'd4) r = 32'(x32 / y32);
      else if (o == 3'd5) r = x[31:0] / y[31:0];
      else if (o == 3'd6) r = 32'(x32 % y32);
      else r = x[31:0] % y[31:0];
      return {{32{r[31]}}, r};
    end
    if (o == 3'd0) return x * y;
    if (o == 3'd1 || o == 3'd2) begin
      px = sx;
      if (o == 3'd1) py = sy;
      else py = {64'b0, y};
      p = px * py;
      return p[127:64];
    end
    if (o == 3'd3) begin
      p = {64'b0, x} * {64'b0, y};
      return p[127:64];
    end
    if (y == 0) return o[1] ? x : '1;
    if (ov && !o[0]) return o[1] ? '0 : MIN;
    if (o == 3'd4) return 64'(sx / sy);
    if (o == 3'd5) return x / y;
    if (o == 3'd6) return 64'(sx % sy);
    return x % y;
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic w, input logic [63:0] x, input logic [63:0] y);
    logic dz, ov;
    dz = w ? y[31:0] == 0 : y == 0;
    ov = w ? (x[31:0] == 32'h8000_0000 && y[31:0] == '1) : (x == MIN && y == '1);
    if (o[2] && (dz || (!o[0] && ov))) return 1;
    if (!o[2] && FAST) return 1;
    return w ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return '1;
      2: return MIN;
      3: return 64'($urandom_range(1, 20));
      4: return -64'($urandom_range(1, 20));
      5: return {32'($urandom), 32'h8000_0000};
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  task automatic run(input string tag, input logic [2:0] o, input logic w, input logic [63:0] x,
                     input logic [63:0] y, input logic [63:0] exp, input int lat_exp);
    int lat = 0;
    op = o;
    word = w;
    a = x;
    b = y;
    start = 1'b1;
    do begin
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end while (!done && lat < 200);
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".lat"}, 64'(lat), 64'(lat_exp));
    chk({tag, ".res"}, result, exp);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [2:0] wops [5] = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [2:0] o;
    logic w;
    logic [63:0] x, y;
    int seen;
    reset = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op = '0;
    word = 1'b0;
    a = '0;
    b = '0;
    #12;
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.res", result, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run("mul", 3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, FAST ? 1 : 65);
    run("mulh", 3'd1, 1'b0, '1, '1, 64'd0, FAST ? 1 : 65);
    run("mulhu", 3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, FAST ? 1 : 65);
    run("div0", 3'd4, 1'b0, 64'd7, 64'd0, '1, 1);
    run("rem0", 3'd6, 1'b0, 64'd7, 64'd0, 64'd7, 1);
    run("divovf", 3'd4, 1'b0, MIN, '1, MIN, 1);
    run("removf", 3'd6, 1'b0, MIN, '1, 64'd0, 1);
    run("divuw", 3'd5, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 33);
    run("remw", 3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 33);
    @(posedge clk);
    #1;
    chk("pulse.done", 64'(done), 64'd0);
    held = result;
    op = 3'd4;
    word = 1'b0;
    a = 64'd7;
    b = 64'd0;
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    chk("flushstart.busy", 64'(busy), 64'd0);
    chk("flushstart.done", 64'(done), 64'd0);
    chk("flushstart.res", result, held);
    a = 64'd1000;
    b = 64'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("flush.busy_on", 64'(busy), 64'd1);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush.busy_off", 64'(busy), 64'd0);
    seen = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    chk("flush.nodone", 64'(seen), 64'd0);
    chk("flush.res", result, held);
    run("divu", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      o = w ? wops[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      x = pick();
      y = pick();
      run("rand", o, w, x, y, model(o, w, x, y), exp_lat(o, w, x, y));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
        chk("rand.pulse", 64'(done), 64'd0);
      end
    end
    op = 3'd5;
    a = 64'd12345;
    b = 64'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.done", 64'(done), 64'd0);
    chk("midrst.res", result, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run("postrst", 3'd5, 1'b0, 64'd12345, 64'd7, 64'd1763, 65);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
